ifetch_unit: RTL

//  Instruction-fetch stage. Owns the PC, runs a req/ack handshake to instruction

---
 rtl/ifetch_unit_pkg.sv | 12 +
 rtl/ifetch_unit.sv | 91 +++++++++
 2 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_KILL = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// presents one fetched word (or a NOP with fetch_stall) to the IF/ID register.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = NOP_WORD_DEFAULT
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_opcplus4,
  output logic [31:0] IF_instruction,
  output logic        fetch_stall
);

  if_state_t   state;
  logic [31:0] pc_reg;
  logic [31:0] req_addr;
  logic [31:0] inst_buf;
  logic [31:0] target;
  logic [31:0] pc_next_seq;

  assign target      = {redirect_pc[31:2], 2'b00};
  assign pc_next_seq = pc_reg + 32'd4;

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state    <= S_REQ;
      pc_reg   <= RESET_VECTOR;
      req_addr <= RESET_VECTOR;
      inst_buf <= NOP_WORD;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            if (redirect) begin
              pc_reg   <= target;
              req_addr <= target;
            end else begin
              inst_buf <= imem_rdata;
              state    <= S_HOLD;
            end
          end else if (redirect) begin
            pc_reg <= target;
            state  <= S_KILL;
          end
        end
        // The bus still owes a word for the old address; wait it out, then
        // refetch from the most recent redirect target.
        S_KILL: begin
          if (redirect)
            pc_reg <= target;
          if (imem_ack) begin
            req_addr <= redirect ? target : pc_reg;
            state    <= S_REQ;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_reg   <= target;
            req_addr <= target;
            state    <= S_REQ;
          end else if (PCWrite) begin
            pc_reg   <= pc_next_seq;
            req_addr <= pc_next_seq;
            state    <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req       = (state != S_HOLD);
    imem_addr      = req_addr;
    fetch_stall    = (state != S_HOLD);
    IF_PC          = pc_reg;
    IF_opcplus4    = pc_next_seq;
    IF_instruction = (state == S_HOLD) ? inst_buf : NOP_WORD;
  end

endmodule
